// File: rtl/sram_pattern_tester.sv
// SRAM pattern tester: writes E(a) then reads and checks, over two passes (pattern, complement).
// Latency: 4 cycles per access with a non-stalling controller; done 16*N cycles after start.
// Backpressure: requests hold in ISSUE states until mem_ready; start is ignored while busy.
module sram_pattern_tester #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic                  mem_req_n,
  output logic                  mem_rh_wl,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_w,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_data_r
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_ISSUE = 3'd1,
    S_WR_WAIT  = 3'd2,
    S_RD_ISSUE = 3'd3,
    S_RD_WAIT  = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_pass_bit;
  logic [DATA_WIDTH-1:0] r_seed;
  logic [15:0]           r_err_cnt;
  logic [ADDR_WIDTH-1:0] r_first_err;

  logic                  w_start_run;
  logic                  w_addr_inc;
  logic                  w_addr_clr;
  logic                  w_pass_set;
  logic                  w_cmp;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_exp;

  // Expected data: address folded to data width, xor seed, complemented on the second pass.
  assign w_exp  = DATA_WIDTH'(r_addr) ^ r_seed ^ {DATA_WIDTH{r_pass_bit}};
  assign w_last = (r_addr == ADDR_LAST);

  // Outputs depend only on registers, never on mem_ready/mem_data_r.
  assign mem_req_n      = !((r_state == S_WR_ISSUE) || (r_state == S_RD_ISSUE));
  assign mem_rh_wl      = !((r_state == S_WR_ISSUE) || (r_state == S_WR_WAIT));
  assign mem_addr       = r_addr;
  assign mem_data_w     = w_exp;
  assign busy           = !((r_state == S_IDLE) || (r_state == S_DONE));
  assign done           = (r_state == S_DONE);
  assign pass           = done && (r_err_cnt == 16'd0);
  assign err_count      = r_err_cnt;
  assign first_err_addr = r_first_err;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state decode and datapath strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_start_run = 1'b0;
    w_addr_inc  = 1'b0;
    w_addr_clr  = 1'b0;
    w_pass_set  = 1'b0;
    w_cmp       = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = S_WR_ISSUE;
          w_start_run = 1'b1;
        end
      end
      S_WR_ISSUE: if (mem_ready) w_state_nxt = S_WR_WAIT;
      S_WR_WAIT: begin
        if (mem_ready) begin
          if (w_last) begin
            w_addr_clr  = 1'b1;
            w_state_nxt = S_RD_ISSUE;
          end else begin
            w_addr_inc  = 1'b1;
            w_state_nxt = S_WR_ISSUE;
          end
        end
      end
      S_RD_ISSUE: if (mem_ready) w_state_nxt = S_RD_WAIT;
      S_RD_WAIT: begin
        if (mem_ready) begin
          w_cmp = 1'b1;
          if (!w_last) begin
            w_addr_inc  = 1'b1;
            w_state_nxt = S_RD_ISSUE;
          end else if (!r_pass_bit) begin
            w_pass_set  = 1'b1;
            w_addr_clr  = 1'b1;
            w_state_nxt = S_WR_ISSUE;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Address counter, pass bit, seed latch and error bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr      <= '0;
      r_pass_bit  <= 1'b0;
      r_seed      <= '0;
      r_err_cnt   <= 16'd0;
      r_first_err <= '0;
    end else if (w_start_run) begin
      r_addr      <= '0;
      r_pass_bit  <= 1'b0;
      r_seed      <= seed;
      r_err_cnt   <= 16'd0;
      r_first_err <= '0;
    end else begin
      if (w_addr_clr)      r_addr <= '0;
      else if (w_addr_inc) r_addr <= r_addr + ADDR_WIDTH'(1);
      if (w_pass_set) r_pass_bit <= 1'b1;
      if (w_cmp && (mem_data_r != w_exp)) begin
        if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
        if (r_err_cnt == 16'd0)    r_first_err <= r_addr;
      end
    end
  end

endmodule

// File: doc/sram_pattern_tester.md
# sram_pattern_tester

Self-checking SRAM test sequencer that sits directly upstream of the SRAM controller in the mini-sramtest design. It drives the controller's request/address/write-data interface and consumes its registered read data. Each run makes two write/read-back passes over a configurable address range, first with an address-derived pattern and then with its complement. Results are error count, first failing address, done and pass flags for the board top level (LEDs/7-seg).

## Interface
Parameters:
- ADDR_WIDTH, 19, SRAM word address width; matches the controller.
- DATA_WIDTH, 8, SRAM data width; matches the controller.
- ADDR_LAST, 2^ADDR_WIDTH-1, last address tested; range is 0..ADDR_LAST, N = ADDR_LAST+1.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  level, sampled in IDLE/DONE; begins a run.
- seed  in  DATA_WIDTH  pattern seed, latched when start is accepted.
- busy  out  1  high from start acceptance until DONE.
- done  out  1  high in DONE state.
- pass  out  1  done && err_count==0.
- err_count  out  16  saturating mismatch count.
- first_err_addr  out  ADDR_WIDTH  address of the first mismatch in the run.
- mem_req_n  out  1  active-low request to the controller.
- mem_rh_wl  out  1  1=read, 0=write.
- mem_addr  out  ADDR_WIDTH  request address.
- mem_data_w  out  DATA_WIDTH  write data.
- mem_ready  in  1  controller idle; a request is taken when mem_ready=1 and mem_req_n=0 in the same cycle.
- mem_data_r  in  DATA_WIDTH  registered read data, valid when mem_ready returns high after a read.

## Operation
- States: IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, DONE. Internal: addr counter, pass bit (0/1), seed_reg.
- Reset values: state IDLE, busy=0, done=0, pass=0, err_count=0, first_err_addr=0, mem_req_n=1, mem_rh_wl=1, mem_addr=0, mem_data_w=0, addr counter=0, pass bit=0, seed_reg=0.
- Expected data: E(a) = (a truncated or zero-extended to DATA_WIDTH) ^ seed_reg, bit-inverted when pass bit = 1.
- IDLE or DONE with start=1 → WR_ISSUE. This clears err_count, first_err_addr, the addr counter and the pass bit, and latches seed.
- start while busy is ignored.
- WR_ISSUE:
  - Drive mem_req_n=0, mem_rh_wl=0, mem_addr=addr, mem_data_w=E(addr).
  - If mem_ready=1 → WR_WAIT; otherwise hold all outputs.
- WR_WAIT:
  - mem_req_n=1.
  - When mem_ready=1: if addr==ADDR_LAST, clear addr → RD_ISSUE; else addr+1 → WR_ISSUE.
- RD_ISSUE: as WR_ISSUE with mem_rh_wl=1 → RD_WAIT.
- RD_WAIT:
  - mem_req_n=1.
  - When mem_ready=1, compare mem_data_r with E(addr).
    - On mismatch: err_count+1, saturating at 16'hFFFF.
    - On the first mismatch of the run (err_count==0 before the increment): first_err_addr=addr.
  - Then:
    - addr<ADDR_LAST: addr+1 → RD_ISSUE.
    - addr==ADDR_LAST and pass bit 0: pass bit=1, addr=0 → WR_ISSUE.
    - addr==ADDR_LAST and pass bit 1: → DONE.
- DONE: done=1, busy=0; results held until the next start or reset.
- Address counter wraps only via the explicit clear at ADDR_LAST; ADDR_LAST=0 is legal (N=1).
- Reset mid-run:
  - All state returns to reset values immediately (asynchronous).
  - mem_req_n=1, so the controller finishes any in-flight access and returns to ready.
  - The first WR_ISSUE after a restart waits for mem_ready.

## Timing
- All outputs are registered or decoded from the state register only; no combinational path from mem_ready or mem_data_r to any output.
- One access = ISSUE (1 cycle, accepted) + WAIT (controller busy 2 cycles, then 1 cycle with mem_ready=1) = 4 cycles with a never-stalling controller.
- Start accepted at edge t → first WR_ISSUE cycle t+1 → done=1 from cycle t+1+16·N.
- mem_req_n is low for exactly one cycle per access when the controller is ready on entry; it stays low across ISSUE cycles while mem_ready=0.
- Read compare happens in the cycle mem_ready returns high; err_count updates on the following edge.

## Test plan
Bench: ADDR_LAST=15, DATA_WIDTH=8, with the SRAM controller and a behavioural async SRAM model.
- Reset check: reset_n low mid-clock → all outputs at reset values within the same cycle; mem_req_n=1.
- Clean run, seed=0xA5:
  - Address 3 is written 0xA6 in pass 0 and 0x59 in pass 1.
  - done rises exactly 257 cycles after start is sampled; pass=1, err_count=0.
- Stuck-at fault, model bit 0 stuck at 0, seed=0xA5:
  - 8 mismatches at even addresses in pass 0, 8 at odd addresses in pass 1.
  - Result: err_count=16, first_err_addr=0, pass=0.
- Start pulses during a run are ignored (done still at 257 cycles). start in DONE restarts the run with counters cleared, and the result matches a fresh run.
- Reset mid-run: reset_n low for 2 cycles during pass-0 reads, then start with seed=0x3C. The controller completes its access, and the run passes with done at 257 cycles.
- Ready stall: hold mem_ready low 5 extra cycles before the first request. mem_req_n stays low and all outputs hold for those cycles; done is delayed by exactly 5 cycles.
